// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: strobes launch/capture with programmable spacing,
// samples the Hamming weight after a settle window and reduces a batch to sum/min/max.
module tdc_meas_ctrl #(
    parameter int N        = 64,
    parameter int HW_W     = $clog2(N) + 1,
    parameter int AVG_LOG2 = 4,
    parameter int DLY_W    = 8,
    parameter int SETTLE   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [DLY_W-1:0]         cfg_capture_dly,
    input  logic [HW_W-1:0]          hw_in,
    output logic                     launch,
    output logic                     capture,
    output logic                     pg_tog,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [HW_W+AVG_LOG2-1:0] res_sum,
    output logic [HW_W-1:0]          res_min,
    output logic [HW_W-1:0]          res_max,
    output logic                     res_err
);

    localparam int SUM_W = HW_W + AVG_LOG2;
    localparam int CNT_W = (DLY_W > $clog2(SETTLE + 1)) ? DLY_W : $clog2(SETTLE + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LAUNCH, S_WAIT, S_CAPTURE, S_SETTLE, S_SAMPLE, S_DONE
    } state_e;

    state_e               state_q, state_d;
    logic [DLY_W-1:0]     dly_q, dly_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W:0]       cnt_inc;
    logic [AVG_LOG2-1:0]  smp_q, smp_d;
    logic [SUM_W-1:0]     acc_q, acc_d;
    logic [HW_W-1:0]      min_q, min_d, max_q, max_d;
    logic                 err_q, err_d;
    logic [HW_W-1:0]      hw_clamp;
    logic                 launch_q, capture_q, pg_tog_q, busy_q, res_valid_q;
    logic [SUM_W-1:0]     res_sum_q, res_sum_d;
    logic [HW_W-1:0]      res_min_q, res_min_d, res_max_q, res_max_d;
    logic                 res_err_q, res_err_d;

    function automatic logic [HW_W-1:0] clamp_hw(input logic [HW_W-1:0] v);
        return (v > HW_W'(N)) ? HW_W'(N) : v;
    endfunction

    assign hw_clamp = clamp_hw(hw_in);
    assign cnt_inc  = {1'b0, cnt_q} + 1'b1;

    always_comb begin
        state_d   = state_q;
        dly_d     = dly_q;
        cnt_d     = '0;
        smp_d     = smp_q;
        acc_d     = acc_q;
        min_d     = min_q;
        max_d     = max_q;
        err_d     = err_q;
        res_sum_d = res_sum_q;
        res_min_d = res_min_q;
        res_max_d = res_max_q;
        res_err_d = res_err_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dly_d   = cfg_capture_dly;
                    smp_d   = '0;
                    acc_d   = '0;
                    min_d   = HW_W'(N);
                    max_d   = '0;
                    err_d   = 1'b0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH:  state_d = (dly_q != '0) ? S_WAIT : S_CAPTURE;
            S_WAIT: begin
                if (cnt_inc == (CNT_W+1)'(dly_q)) state_d = S_CAPTURE;
                else                              cnt_d   = cnt_inc[CNT_W-1:0];
            end
            S_CAPTURE: state_d = S_SETTLE;
            S_SETTLE: begin
                if (cnt_inc == (CNT_W+1)'(SETTLE)) state_d = S_SAMPLE;
                else                               cnt_d   = cnt_inc[CNT_W-1:0];
            end
            S_SAMPLE: begin
                acc_d = acc_q + SUM_W'(hw_clamp);
                min_d = (hw_clamp < min_q) ? hw_clamp : min_q;
                max_d = (hw_clamp > max_q) ? hw_clamp : max_q;
                err_d = err_q | (hw_clamp != hw_in);
                smp_d = smp_q + 1'b1;
                if (&smp_q) begin
                    res_sum_d = acc_d;
                    res_min_d = min_d;
                    res_max_d = max_d;
                    res_err_d = err_d;
                    state_d   = S_DONE;
                end else begin
                    state_d = S_LAUNCH;
                end
            end
            S_DONE:    if (res_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Abort discards the batch, including a result that would load this cycle.
        if (abort && state_q != S_IDLE && state_q != S_DONE) begin
            state_d   = S_IDLE;
            res_sum_d = res_sum_q;
            res_min_d = res_min_q;
            res_max_d = res_max_q;
            res_err_d = res_err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            launch_q    <= 1'b0;
            capture_q   <= 1'b0;
            pg_tog_q    <= 1'b0;
            busy_q      <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_min_q   <= '0;
            res_max_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            launch_q    <= (state_d == S_LAUNCH);
            capture_q   <= (state_d == S_CAPTURE);
            pg_tog_q    <= pg_tog_q ^ (state_d == S_LAUNCH);
            busy_q      <= (state_d != S_IDLE) && (state_d != S_DONE);
            res_valid_q <= (state_d == S_DONE);
            res_sum_q   <= res_sum_d;
            res_min_q   <= res_min_d;
            res_max_q   <= res_max_d;
            res_err_q   <= res_err_d;
        end
    end

    // Batch working registers are reinitialised on every accepted start.
    always_ff @(posedge clk) begin
        dly_q <= dly_d;
        cnt_q <= cnt_d;
        smp_q <= smp_d;
        acc_q <= acc_d;
        min_q <= min_d;
        max_q <= max_d;
        err_q <= err_d;
    end

    assign launch    = launch_q;
    assign capture   = capture_q;
    assign pg_tog    = pg_tog_q;
    assign busy      = busy_q;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_min   = res_min_q;
    assign res_max   = res_max_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Self-checking bench for tdc_meas_ctrl: directed and random batches against a
// timing/result model derived from the per-sample period and batch reduction rules.
module tb_tdc_meas_ctrl;

    localparam int N        = 64;
    localparam int HW_W     = 7;
    localparam int AVG_LOG2 = 2;
    localparam int DLY_W    = 8;
    localparam int SETTLE   = 2;
    localparam int B        = 1 << AVG_LOG2;

    logic                     clk = 1'b0;
    logic                     rst, start, abort, res_ready;
    logic [DLY_W-1:0]         cfg_capture_dly;
    logic [HW_W-1:0]          hw_in;
    logic                     launch, capture, pg_tog, busy, res_valid, res_err;
    logic [HW_W+AVG_LOG2-1:0] res_sum;
    logic [HW_W-1:0]          res_min, res_max;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_sum, exp_min, exp_max, exp_err;
    bit pg_exp;
    int hw_seq[B];

    always #5 clk = ~clk;

    tdc_meas_ctrl #(
        .N(N), .HW_W(HW_W), .AVG_LOG2(AVG_LOG2), .DLY_W(DLY_W), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .cfg_capture_dly(cfg_capture_dly), .hw_in(hw_in),
        .launch(launch), .capture(capture), .pg_tog(pg_tog), .busy(busy),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_min(res_min), .res_max(res_max), .res_err(res_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_results(input string tag);
        check_eq({tag, ".sum"}, res_sum, exp_sum);
        check_eq({tag, ".min"}, res_min, exp_min);
        check_eq({tag, ".max"}, res_max, exp_max);
        check_eq({tag, ".err"}, res_err, exp_err);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, ".launch"}, launch, 0);
        check_eq({tag, ".capture"}, capture, 0);
        check_eq({tag, ".busy"}, busy, 0);
        check_eq({tag, ".valid"}, res_valid, 0);
        check_eq({tag, ".pg_tog"}, pg_tog, pg_exp);
        check_results(tag);
    endtask

    // stop_kind: 0 none, 1 abort, 2 reset, applied during cycle stop_at
    task automatic run_batch(input int d, input bit rnd, input int hold,
                             input int stop_at, input int stop_kind);
        int p, off, v;
        int smp[B];
        p = 3 + d + SETTLE;
        for (int k = 0; k < B; k++)
            smp[k] = rnd ? (($urandom_range(0, 3) == 0) ? $urandom_range(N + 1, 127)
                                                         : $urandom_range(0, N))
                         : hw_seq[k];
        cfg_capture_dly = DLY_W'(d);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int n = 1; n <= B * p; n++) begin
            off = (n - 1) % p;
            if (n == stop_at) begin
                if (stop_kind == 1) abort = 1'b1;
                else                rst   = 1'b1;
                step();
                abort = 1'b0;
                rst   = 1'b0;
                if (stop_kind == 2) begin
                    pg_exp = 1'b0; exp_sum = 0; exp_min = 0; exp_max = 0; exp_err = 0;
                end
                check_quiet(stop_kind == 1 ? "abort" : "rst");
                for (int i = 0; i < 3; i++) begin
                    step();
                    check_eq("post_stop.launch", launch, 0);
                    check_eq("post_stop.valid", res_valid, 0);
                end
                return;
            end
            if (off == 0) pg_exp = ~pg_exp;
            check_eq("run.launch", launch, off == 0);
            check_eq("run.capture", capture, off == d + 1);
            check_eq("run.busy", busy, 1);
            check_eq("run.valid", res_valid, 0);
            check_eq("run.pg_tog", pg_tog, pg_exp);
            check_eq("run.sum_held", res_sum, exp_sum);
            if (n == 2) cfg_capture_dly = DLY_W'($urandom_range(0, 255));
            hw_in = (n % p == 0) ? HW_W'(smp[n / p - 1]) : HW_W'($urandom_range(0, 127));
            step();
        end
        exp_sum = 0; exp_min = N; exp_max = 0; exp_err = 0;
        for (int k = 0; k < B; k++) begin
            v = (smp[k] > N) ? N : smp[k];
            if (smp[k] > N) exp_err = 1;
            exp_sum += v;
            if (v < exp_min) exp_min = v;
            if (v > exp_max) exp_max = v;
        end
        check_eq("done.valid", res_valid, 1);
        check_eq("done.busy", busy, 0);
        check_eq("done.launch", launch, 0);
        check_results("done");
        for (int h = 0; h < hold; h++) begin
            start = 1'($urandom_range(0, 1));
            abort = 1'($urandom_range(0, 1));
            step();
            check_eq("hold.valid", res_valid, 1);
            check_eq("hold.launch", launch, 0);
            check_eq("hold.busy", busy, 0);
            check_results("hold");
        end
        start = 1'b0;
        abort = 1'b0;
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check_eq("ack.valid", res_valid, 0);
        check_eq("ack.busy", busy, 0);
        check_results("ack");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
        cfg_capture_dly = '0; hw_in = '0;
        pg_exp = 1'b0; exp_sum = 0; exp_min = 0; exp_max = 0; exp_err = 0;
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        check_quiet("reset");
        rst = 1'b0;
        step();
        check_quiet("idle");

        hw_seq = '{20, 20, 20, 20};
        run_batch(3, 1'b0, 0, 0, 0);
        check_eq("const20.pg_end", pg_tog, 0);

        hw_seq = '{0, 64, 10, 5};
        run_batch(0, 1'b0, 0, 0, 0);

        hw_seq = '{127, 10, 10, 10};
        run_batch(2, 1'b0, 10, 0, 0);

        hw_seq = '{33, 1, 50, 7};
        run_batch(1, 1'b0, 0, 0, 0);

        run_batch(3, 1'b1, 0, (3 + 3 + SETTLE) + 2, 1);
        run_batch(4, 1'b1, 2, 0, 0);
        run_batch(3, 1'b1, 0, (3 + 3 + SETTLE) + 2, 2);
        check_quiet("after_rst");

        for (int i = 0; i < 12; i++)
            run_batch($urandom_range(0, 6), 1'b1, $urandom_range(0, 3), 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
